// File: rtl/bf16_pkg.sv
// Shared definitions for the sequential BF16 multiplier and its
// normalise/round stage: field widths, bias, special encodings, FSM states
// and the packed result payload.
package bf16_pkg;

    localparam int unsigned SIG_W     = 8;
    localparam int unsigned EXP_W     = 8;
    localparam int unsigned BF16_W    = 16;
    localparam int unsigned BF16_BIAS = 127;
    localparam int unsigned ACC_W     = 2 * SIG_W;

    localparam logic [EXP_W-1:0]  EXP_ALL_ONES = 8'hFF;
    localparam logic [BF16_W-1:0] BF16_INF_POS = 16'h7F80;
    localparam logic [BF16_W-1:0] BF16_ZERO    = 16'h0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_e;

    // Product word plus its status flags, as presented on the result port.
    typedef struct packed {
        logic [BF16_W-1:0] res;
        logic              exc;
        logic              ovf;
        logic              unf;
    } mul_res_t;

    // Significand with hidden bit; the hidden bit is 0 for a zero exponent.
    function automatic logic [SIG_W-1:0] sig_of(input logic [BF16_W-1:0] x);
        return {|x[14:7], x[6:0]};
    endfunction

    // Two's-complement magnitude of an INT8 operand (-128 maps to 0x80).
    function automatic logic [SIG_W-1:0] mag8(input logic [7:0] x);
        return x[7] ? 8'(~x + 8'd1) : x;
    endfunction

endpackage

// File: rtl/bf16_mul_seq_if.sv
// Operand/result handshake bundle for bf16_mul_seq.
//   i_vld/o_rdy      operand handshake, i_a/i_b BF16 operands
//   o_vld/i_rdy      result handshake, o_res product
//   o_exception/o_overflow/o_underflow  status, valid with o_vld
//   i_int8           INT8 mode select (only with BF16_MUL_SEQ_INT8_EN)
interface bf16_mul_seq_if;

    logic        i_vld;
    logic        o_rdy;
    logic [15:0] i_a;
    logic [15:0] i_b;
    logic        o_vld;
    logic        i_rdy;
    logic [15:0] o_res;
    logic        o_exception;
    logic        o_overflow;
    logic        o_underflow;
`ifdef BF16_MUL_SEQ_INT8_EN
    logic        i_int8;

    modport master (
        output i_vld, i_a, i_b, i_rdy, i_int8,
        input  o_rdy, o_vld, o_res, o_exception, o_overflow, o_underflow
    );
    modport slave (
        input  i_vld, i_a, i_b, i_rdy, i_int8,
        output o_rdy, o_vld, o_res, o_exception, o_overflow, o_underflow
    );
`else
    modport master (
        output i_vld, i_a, i_b, i_rdy,
        input  o_rdy, o_vld, o_res, o_exception, o_overflow, o_underflow
    );
    modport slave (
        input  i_vld, i_a, i_b, i_rdy,
        output o_rdy, o_vld, o_res, o_exception, o_overflow, o_underflow
    );
`endif

endinterface

// File: rtl/bf16_norm_round.sv
// Combinational normalise/round/classify of a raw significand product.
// Ports:
//   i_acc     16b raw significand product
//   i_exp_a/b biased exponent fields of the operands
//   i_sign    result sign
//   i_exc     an operand had an all-ones exponent
//   o_res_c   packed BF16 result with exception/overflow/underflow flags
module bf16_norm_round
    import bf16_pkg::*;
#(
    parameter int unsigned BIAS = BF16_BIAS
) (
    input  logic [ACC_W-1:0] i_acc,
    input  logic [EXP_W-1:0] i_exp_a,
    input  logic [EXP_W-1:0] i_exp_b,
    input  logic             i_sign,
    input  logic             i_exc,
    output mul_res_t         o_res_c
);

    logic             w_norm;
    logic [ACC_W-1:0] w_pn;
    logic             w_rnd;
    logic [6:0]       w_man;
    logic [EXP_W:0]   w_exp9;
    logic             w_zero;
    logic             w_ovf;
    logic             w_unf;

    // Product of two 1.x values lies in [1,4): bit 15 selects the shift.
    always_comb begin
        w_norm = i_acc[ACC_W-1];
        w_pn   = w_norm ? i_acc : (i_acc << 1);
        // Round up only when above the halfway point; the carry wraps in 7 bits.
        w_rnd  = w_pn[7] & (|w_pn[6:0]);
        w_man  = w_pn[14:8] + 7'(w_rnd);
        // 9-bit exponent: bit 8 set means out of range, bit 7 tells which side.
        w_exp9 = (EXP_W+1)'(i_exp_a) + (EXP_W+1)'(i_exp_b)
               - (EXP_W+1)'(BIAS) + (EXP_W+1)'(w_norm);
        w_zero = !i_exc && (w_man == 7'd0);
        w_ovf  = w_exp9[8] && !w_exp9[7] && !w_zero;
        w_unf  = w_exp9[8] &&  w_exp9[7] && !w_zero;

        o_res_c     = '0;
        o_res_c.exc = i_exc;
        o_res_c.ovf = w_ovf;
        o_res_c.unf = w_unf;
        if (w_ovf) begin
            o_res_c.res = {i_sign, BF16_INF_POS[14:0]};
        end else if (w_unf) begin
            o_res_c.res = {i_sign, BF16_ZERO[14:0]};
        end else if (i_exc) begin
            o_res_c.res = BF16_ZERO;
        end else begin
            o_res_c.res = {i_sign, w_exp9[7:0], w_man};
        end
    end

endmodule

// File: rtl/bf16_mul_seq.sv
// Multi-cycle BF16 multiplier using a radix-2 shift-add significand datapath.
// Optional INT8 mode is enabled by defining BF16_MUL_SEQ_INT8_EN.
// Ports:
//   i_clk   clock, rising edge
//   i_rst   synchronous active-low reset
//   bus     bf16_mul_seq_if.slave: operand handshake (i_vld/o_rdy, i_a, i_b,
//           i_int8 when enabled) and result handshake (o_vld/i_rdy, o_res,
//           o_exception, o_overflow, o_underflow)
module bf16_mul_seq
    import bf16_pkg::*;
#(
    parameter int unsigned SIG_W = bf16_pkg::SIG_W,
    parameter int unsigned EXP_W = bf16_pkg::EXP_W,
    parameter int unsigned BIAS  = BF16_BIAS
) (
    input  logic           i_clk,
    input  logic           i_rst,
    bf16_mul_seq_if.slave  bus
);

    localparam int unsigned CNT_W = (SIG_W > 1) ? $clog2(SIG_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SIG_W - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [ACC_W-1:0]  r_acc;
    logic [SIG_W-1:0]  r_op_a;
    logic [SIG_W-1:0]  r_op_b;
    logic [EXP_W-1:0]  r_exp_a;
    logic [EXP_W-1:0]  r_exp_b;
    logic              r_sign;
    logic              r_exc;
    logic              r_int8;
    logic              r_rdy;
    logic              r_vld;
    mul_res_t          r_out;

    logic              w_accept;
    logic              w_step;
    logic              w_norm_ld;
    logic              w_int_ld;
    logic              w_release;
    logic              w_int8_in;
    logic [SIG_W-1:0]  w_op_a;
    logic [SIG_W-1:0]  w_op_b;
    logic              w_sign;
    logic [ACC_W-1:0]  w_acc_nxt;
    logic              w_i8_neg;
    mul_res_t          w_int_res;
    mul_res_t          w_nr_res;

    // Operand capture values for the selected mode.
    always_comb begin
`ifdef BF16_MUL_SEQ_INT8_EN
        w_int8_in = bus.i_int8;
`else
        w_int8_in = 1'b0;
`endif
        if (w_int8_in) begin
            w_op_a = mag8(bus.i_a[7:0]);
            w_op_b = mag8(bus.i_b[7:0]);
            w_sign = bus.i_a[7] ^ bus.i_b[7];
        end else begin
            w_op_a = sig_of(bus.i_a);
            w_op_b = sig_of(bus.i_b);
            w_sign = bus.i_a[15] ^ bus.i_b[15];
        end
    end

    // One shift-add step; the INT8 result is taken from the final step's sum.
    always_comb begin
        w_acc_nxt = r_acc;
        if (r_op_b[r_cnt]) begin
            w_acc_nxt = r_acc + (ACC_W'(r_op_a) << r_cnt);
        end
        w_i8_neg  = r_sign && (w_acc_nxt != '0);
        w_int_res = '0;
        if (!w_i8_neg && (w_acc_nxt > ACC_W'(127))) begin
            w_int_res.res = 16'h007F;
            w_int_res.ovf = 1'b1;
        end else if (w_i8_neg && (w_acc_nxt > ACC_W'(128))) begin
            w_int_res.res = 16'h0080;
            w_int_res.unf = 1'b1;
        end else begin
            w_int_res.res = {8'h00, w_i8_neg ? 8'(~w_acc_nxt[7:0] + 8'd1)
                                             : w_acc_nxt[7:0]};
        end
    end

    bf16_norm_round #(
        .BIAS (BIAS)
    ) u_norm_round (
        .i_acc   (r_acc),
        .i_exp_a (r_exp_a),
        .i_exp_b (r_exp_b),
        .i_sign  (r_sign),
        .i_exc   (r_exc),
        .o_res_c (w_nr_res)
    );

    // Next-state and datapath strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_norm_ld   = 1'b0;
        w_int_ld    = 1'b0;
        w_release   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_vld && r_rdy) begin
                    w_accept    = 1'b1;
                    w_state_nxt = MULT;
                end
            end
            MULT: begin
                w_step = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    if (r_int8) begin
                        w_int_ld    = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_state_nxt = NORM;
                    end
                end
            end
            NORM: begin
                w_norm_ld   = 1'b1;
                w_state_nxt = DONE;
            end
            DONE: begin
                if (bus.i_rdy) begin
                    w_release   = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State, handshake and datapath registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_exp_a <= '0;
            r_exp_b <= '0;
            r_sign  <= 1'b0;
            r_exc   <= 1'b0;
            r_int8  <= 1'b0;
            r_rdy   <= 1'b1;
            r_vld   <= 1'b0;
            r_out   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rdy   <= (w_state_nxt == IDLE);
            r_vld   <= (w_state_nxt == DONE);
            if (w_accept) begin
                r_op_a  <= w_op_a;
                r_op_b  <= w_op_b;
                r_sign  <= w_sign;
                r_exp_a <= bus.i_a[14:7];
                r_exp_b <= bus.i_b[14:7];
                r_exc   <= (bus.i_a[14:7] == EXP_ALL_ONES) ||
                           (bus.i_b[14:7] == EXP_ALL_ONES);
                r_int8  <= w_int8_in;
                r_acc   <= '0;
                r_cnt   <= '0;
            end
            if (w_step) begin
                r_acc <= w_acc_nxt;
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_norm_ld) begin
                r_out <= w_nr_res;
            end
            if (w_int_ld) begin
                r_out <= w_int_res;
            end
            if (w_release) begin
                r_out <= '0;
            end
        end
    end

    assign bus.o_rdy       = r_rdy;
    assign bus.o_vld       = r_vld;
    assign bus.o_res       = r_out.res;
    assign bus.o_exception = r_out.exc;
    assign bus.o_overflow  = r_out.ovf;
    assign bus.o_underflow = r_out.unf;

endmodule

// File: tb/tb_bf16_mul_seq.sv
// Self-checking bench for bf16_mul_seq: directed vectors, backpressure,
// mid-operation reset and randomized operands against a reference model.
module tb_bf16_mul_seq;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bf16_mul_seq_if bus ();

    bf16_mul_seq dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Reference: real-valued significand product, then the rounding/range rules.
    function automatic logic [18:0] ref_bf16(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, sa, sb, p, pn, man, e, norm;
        logic sign, exc, zero, ovf, unf;
        logic [8:0] e9;
        logic [15:0] res;
        ea   = int'(a[14:7]);
        eb   = int'(b[14:7]);
        sa   = (ea != 0 ? 128 : 0) + int'(a[6:0]);
        sb   = (eb != 0 ? 128 : 0) + int'(b[6:0]);
        p    = sa * sb;
        norm = (p >= 32768) ? 1 : 0;
        pn   = (norm == 1) ? p : p * 2;
        man  = ((pn / 256) % 128 + ((((pn / 128) % 2) == 1 && (pn % 128) != 0) ? 1 : 0)) % 128;
        sign = a[15] ^ b[15];
        exc  = (ea == 255) || (eb == 255);
        e    = ea + eb - 127 + norm;
        zero = !exc && (man == 0);
        ovf  = !zero && (e >= 256) && (e < 384);
        unf  = !zero && ((e < 0) || (e >= 384));
        e9   = 9'(e);
        if (ovf)      res = {sign, 8'hFF, 7'h00};
        else if (unf) res = {sign, 15'h0000};
        else if (exc) res = 16'h0000;
        else          res = {sign, e9[7:0], 7'(man)};
        return {res, exc, ovf, unf};
    endfunction

    function automatic logic [18:0] ref_int8(input logic [15:0] a, input logic [15:0] b);
        logic signed [7:0] xa, xb;
        int prod;
        xa   = a[7:0];
        xb   = b[7:0];
        prod = int'(xa) * int'(xb);
        if (prod > 127)       return {16'h007F, 3'b010};
        else if (prod < -128) return {16'h0080, 3'b001};
        else                  return {8'h00, 8'(prod), 3'b000};
    endfunction

    // Issue one operation, check latency, busy o_rdy, result and release.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic m8,
                         input logic [18:0] expv, input string tag);
        int n;
        logic busy_bad, seen;
        chk({tag, "_rdy_idle"}, 32'(bus.o_rdy), 32'd1);
        bus.i_a   = a;
        bus.i_b   = b;
`ifdef BF16_MUL_SEQ_INT8_EN
        bus.i_int8 = m8;
`endif
        bus.i_vld = 1'b1;
        n = 0;
        busy_bad = 1'b0;
        seen = 1'b0;
        while (n < 20 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                bus.i_vld = 1'b0;
                bus.i_a   = 16'($urandom);
                bus.i_b   = 16'($urandom);
            end
            if (bus.o_vld) seen = 1'b1;
            else if (bus.o_rdy) busy_bad = 1'b1;
        end
        chk({tag, "_latency"}, 32'(n), m8 ? 32'd9 : 32'd10);
        chk({tag, "_rdy_busy"}, 32'(busy_bad), 32'd0);
        chk({tag, "_result"},
            32'({bus.o_res, bus.o_exception, bus.o_overflow, bus.o_underflow}), 32'(expv));
        if (bus.i_rdy) begin
            @(posedge clk);
            #1;
            chk({tag, "_release"}, 32'({bus.o_vld, bus.o_rdy}), 32'b01);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] a, b;
        logic m8;
        logic [15:0] held;

        bus.i_vld = 1'b0;
        bus.i_a   = 16'h0;
        bus.i_b   = 16'h0;
        bus.i_rdy = 1'b1;
`ifdef BF16_MUL_SEQ_INT8_EN
        bus.i_int8 = 1'b0;
`endif
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vld", 32'(bus.o_vld), 32'd0);
        chk("reset_rdy", 32'(bus.o_rdy), 32'd1);
        chk("reset_res", 32'({bus.o_res, bus.o_exception, bus.o_overflow, bus.o_underflow}), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors (overflow/underflow use nonzero mantissas).
        do_op(16'h3F80, 16'h3F80, 1'b0, {16'h3F80, 3'b000}, "one_x_one");
        do_op(16'h4000, 16'h4040, 1'b0, {16'h40C0, 3'b000}, "two_x_three");
        do_op(16'hBFC0, 16'h4020, 1'b0, {16'hC070, 3'b000}, "neg_mul");
        do_op(16'h7F40, 16'h7F40, 1'b0, {16'h7F80, 3'b010}, "overflow");
        do_op(16'h00C0, 16'h00C0, 1'b0, {16'h0000, 3'b001}, "underflow");
        do_op(16'h7F80, 16'h3F80, 1'b0, {16'h0000, 3'b100}, "exception");

        // Backpressure: result held, new operands ignored.
        bus.i_rdy = 1'b0;
        do_op(16'h4000, 16'h4040, 1'b0, {16'h40C0, 3'b000}, "bp");
        held = bus.o_res;
        for (int i = 0; i < 5; i++) begin
            bus.i_vld = 1'b1;
            bus.i_a   = 16'h3F80;
            bus.i_b   = 16'h4000;
            @(posedge clk);
            #1;
            chk("bp_hold_vld", 32'(bus.o_vld), 32'd1);
            chk("bp_hold_res", 32'(bus.o_res), 32'(held));
            chk("bp_hold_rdy", 32'(bus.o_rdy), 32'd0);
        end
        bus.i_vld = 1'b0;
        bus.i_rdy = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release", 32'({bus.o_vld, bus.o_rdy}), 32'b01);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_queue", 32'(bus.o_vld), 32'd0);

        // Reset during MULT abandons the operation.
        bus.i_a   = 16'h4000;
        bus.i_b   = 16'h4040;
        bus.i_vld = 1'b1;
        @(posedge clk);
        #1;
        bus.i_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_mid_rdy", 32'(bus.o_rdy), 32'd1);
        chk("rst_mid_vld", 32'(bus.o_vld), 32'd0);
        rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("rst_mid_silent", 32'(bus.o_vld), 32'd0);
        do_op(16'h4000, 16'h4040, 1'b0, {16'h40C0, 3'b000}, "after_rst");

`ifdef BF16_MUL_SEQ_INT8_EN
        do_op(16'h000C, 16'h00F6, 1'b1, ref_int8(16'h000C, 16'h00F6), "i8_neg120");
        do_op(16'h0005, 16'h00FD, 1'b1, {16'h00F1, 3'b000}, "i8_neg15");
        do_op(16'h0010, 16'h0010, 1'b1, {16'h007F, 3'b010}, "i8_sat_pos");
        do_op(16'h0080, 16'h0002, 1'b1, {16'h0080, 3'b001}, "i8_sat_neg");
`endif

        // Randomized operands; half constrained near unit exponent.
        for (int i = 0; i < 3000; i++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            m8 = 1'b0;
            if (i % 2 == 0) begin
                a[14:7] = 8'($urandom_range(110, 145));
                b[14:7] = 8'($urandom_range(110, 145));
            end
`ifdef BF16_MUL_SEQ_INT8_EN
            m8 = (i % 5 == 0);
`endif
            do_op(a, b, m8, m8 ? ref_int8(a, b) : ref_bf16(a, b), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
